// File: rtl/cbf_parallel_filter.sv
// Multi-channel control-bounded filter back end: per-channel complex recursion, channel sum, scaled/saturated/decimated output.
// Latency 2 cycles accept->out, one sample per clock; no backpressure (in_valid strobe only, out_valid one-cycle strobe).
module cbf_parallel_filter #(
  parameter int N      = 3,
  parameter int width  = 16,
  parameter int DW     = 24,
  parameter int FRAC   = 16,
  parameter logic [N*DW-1:0] LAMBDA_RE = {N{24'd63570}},
  parameter logic [N*DW-1:0] LAMBDA_IM = {N{24'd0}},
  parameter logic [N*DW-1:0] W_RE      = {N{24'd6554}},
  parameter logic [N*DW-1:0] W_IM      = {N{24'd0}},
  parameter int OSHIFT = 8,
  parameter int DECIM  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            in,
  input  logic                    in_valid,
  output logic signed [width-1:0] out,
  output logic                    out_valid
);

  localparam int PW = 2*DW + 2;
  localparam int SW = DW + $clog2(N) + 1;
  localparam int XW = ((SW > width) ? SW : width) + 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [PW-1:0] DMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] DMIN = ~DMAX;
  localparam logic signed [XW-1:0] OMAX = {{(XW-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = ~OMAX;
  localparam logic [CW-1:0]        CLAST = CW'(DECIM - 1);

  // One recursion component: ((a*b -/+ c*d) >>> FRAC) +/- w, saturated to DW bits.
  function automatic logic signed [DW-1:0] rec_step(
    input logic signed [DW-1:0] a, b, c, d, w,
    input logic                 add_cd,
    input logic                 pos_w
  );
    logic signed [PW-1:0] pa, pb, pc, pd, pw, p, q;
    pa = a; pb = b; pc = c; pd = d; pw = w;
    p = add_cd ? (pa*pb + pc*pd) : (pa*pb - pc*pd);
    q = (p >>> FRAC) + (pos_w ? pw : -pw);
    if (q > DMAX)      rec_step = DMAX[DW-1:0];
    else if (q < DMIN) rec_step = DMIN[DW-1:0];
    else               rec_step = q[DW-1:0];
  endfunction

  logic signed [DW-1:0] s_re [N];
  logic signed [DW-1:0] s_im [N];
  logic signed [DW-1:0] nx_re [N];
  logic signed [DW-1:0] nx_im [N];
  logic signed [SW-1:0] sum_c, sum_r;
  logic signed [XW-1:0] sum_x, sh;
  logic                 v0, v1;
  logic [CW-1:0]        cnt;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      nx_re[k] = rec_step($signed(LAMBDA_RE[k*DW +: DW]), s_re[k],
                          $signed(LAMBDA_IM[k*DW +: DW]), s_im[k],
                          $signed(W_RE[k*DW +: DW]), 1'b0, in[k]);
      nx_im[k] = rec_step($signed(LAMBDA_RE[k*DW +: DW]), s_im[k],
                          $signed(LAMBDA_IM[k*DW +: DW]), s_re[k],
                          $signed(W_IM[k*DW +: DW]), 1'b1, in[k]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N; k++) sum_c = sum_c + SW'(s_re[k]);
  end

  always_comb begin
    sum_x = XW'(sum_r);
    sh    = sum_x >>> OSHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        s_re[k] <= '0;
        s_im[k] <= '0;
      end
      v0 <= 1'b0;
    end else begin
      if (in_valid) begin
        for (int k = 0; k < N; k++) begin
          s_re[k] <= nx_re[k];
          s_im[k] <= nx_im[k];
        end
      end
      v0 <= in_valid;
    end
  end

  // Sum stage runs every edge; v1 marks which sums belong to accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= '0;
      v1    <= 1'b0;
    end else begin
      sum_r <= sum_c;
      v1    <= v0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (v1) begin
        cnt <= (cnt == CLAST) ? '0 : cnt + 1'b1;
        if (cnt == CLAST) begin
          out_valid <= 1'b1;
          if (sh > OMAX)      out <= OMAX[width-1:0];
          else if (sh < OMIN) out <= OMIN[width-1:0];
          else                out <= sh[width-1:0];
        end
      end
    end
  end

endmodule
